// File: rtl/film_scanner_pkg.sv
// Shared scan-controller types and default timing constants (80 MHz clocks).
// Defaults give a 10 kHz step rate, 1 ms settle and 1 ms driver wake time.
package film_scanner_pkg;

  localparam int DEF_STEP_HALF_CYC  = 4000;
  localparam int DEF_SETTLE_CYC     = 80000;
  localparam int DEF_WAKE_CYC       = 80000;
  localparam int DEF_HOME_MAX_STEPS = 20000;
  localparam int STEP_CNT_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAKE,
    ST_HOME,
    ST_STEP,
    ST_SETTLE,
    ST_EXPOSE,
    ST_FAULT
  } scan_state_e;

  typedef enum logic [1:0] {
    PG_IDLE,
    PG_HIGH,
    PG_LOW
  } pulse_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Emits `count` step pulses of HALF_CYC high / HALF_CYC low; starts the cycle after req.
// tick marks the last low cycle of each pulse; cancel returns to idle on the next edge.
module step_pulse_gen
  import film_scanner_pkg::*;
#(
  parameter int HALF_CYC = DEF_STEP_HALF_CYC,
  parameter int CNT_W    = STEP_CNT_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             req,
  input  logic             cancel,
  input  logic [CNT_W-1:0] count,
  output logic             step,
  output logic             busy,
  output logic             tick,
  output logic             last
);

  localparam int HW = $clog2(max2(HALF_CYC, 2));

  pulse_state_e     pg_q, pg_d;
  logic [HW-1:0]    half_q, half_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             half_end;

  assign half_end = (half_q == HW'(HALF_CYC - 1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pg_q   <= PG_IDLE;
      half_q <= '0;
      rem_q  <= '0;
    end else begin
      pg_q   <= pg_d;
      half_q <= half_d;
      rem_q  <= rem_d;
    end
  end

  always_comb begin
    pg_d   = pg_q;
    half_d = half_q;
    rem_d  = rem_q;
    if (cancel) begin
      pg_d   = PG_IDLE;
      half_d = '0;
      rem_d  = '0;
    end else begin
      case (pg_q)
        PG_IDLE: begin
          if (req && (count != '0)) begin
            pg_d   = PG_HIGH;
            half_d = '0;
            rem_d  = count;
          end
        end
        PG_HIGH: begin
          if (half_end) begin
            pg_d   = PG_LOW;
            half_d = '0;
          end else begin
            half_d = half_q + 1'b1;
          end
        end
        PG_LOW: begin
          if (half_end) begin
            half_d = '0;
            rem_d  = rem_q - 1'b1;
            pg_d   = (rem_q == CNT_W'(1)) ? PG_IDLE : PG_HIGH;
          end else begin
            half_d = half_q + 1'b1;
          end
        end
        default: pg_d = PG_IDLE;
      endcase
    end
  end

  always_comb begin
    step = (pg_q == PG_HIGH);
    busy = (pg_q != PG_IDLE);
    tick = (pg_q == PG_LOW) && half_end;
    last = tick && (rem_q == CNT_W'(1));
  end

endmodule

// File: rtl/scan_sequencer.sv
// Scan controller: wake/home the carriage, then step, settle and expose one line per pass.
// start->busy 1 clock; async driver inputs act after 3 clocks; abort/fault return to IDLE.
module scan_sequencer
  import film_scanner_pkg::*;
#(
  parameter int STEP_HALF_CYC  = DEF_STEP_HALF_CYC,
  parameter int SETTLE_CYC     = DEF_SETTLE_CYC,
  parameter int WAKE_CYC       = DEF_WAKE_CYC,
  parameter int HOME_MAX_STEPS = DEF_HOME_MAX_STEPS
) (
  input  logic        clk_80M,
  input  logic        nrst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] num_lines,
  input  logic [7:0]  steps_per_line,
  input  logic        line_done,
  input  logic        mtr_nhome,
  input  logic        mtr_nflt,
  output logic        mtr_step,
  output logic        mtr_dir,
  output logic        mtr_nen,
  output logic        mtr_nrst,
  output logic        mtr_slp,
  output logic        ccd_en,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] line_cnt
);

  localparam int TMR_W = $clog2(max2(max2(SETTLE_CYC, WAKE_CYC), 2));

  scan_state_e           state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [15:0]           num_lines_q, num_lines_d;
  logic [7:0]            spl_q, spl_d;
  logic [15:0]           line_cnt_q, line_cnt_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic                  nhome_meta_q, nhome_s_q;
  logic                  nflt_meta_q, nflt_s_q;
  logic                  pg_req, pg_cancel;
  logic [STEP_CNT_W-1:0] pg_count;
  logic                  pg_step, pg_busy, pg_tick, pg_last;

  // Home switch and driver fault are asynchronous to clk_80M.
  always_ff @(posedge clk_80M) begin
    if (!nrst) begin
      nhome_meta_q <= 1'b1;
      nhome_s_q    <= 1'b1;
      nflt_meta_q  <= 1'b1;
      nflt_s_q     <= 1'b1;
    end else begin
      nhome_meta_q <= mtr_nhome;
      nhome_s_q    <= nhome_meta_q;
      nflt_meta_q  <= mtr_nflt;
      nflt_s_q     <= nflt_meta_q;
    end
  end

  always_ff @(posedge clk_80M) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      num_lines_q <= '0;
      spl_q       <= '0;
      line_cnt_q  <= '0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      num_lines_q <= num_lines_d;
      spl_q       <= spl_d;
      line_cnt_q  <= line_cnt_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_lines_d = num_lines_q;
    spl_d       = spl_q;
    line_cnt_d  = line_cnt_q;
    dir_d       = dir_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    pg_req      = 1'b0;
    pg_count    = '0;
    // Fault outranks abort; FAULT itself always falls back to IDLE.
    if (state_q == ST_FAULT) begin
      state_d = ST_IDLE;
    end else if ((state_q != ST_IDLE) && !nflt_s_q) begin
      state_d = ST_FAULT;
    end else if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (fault_q) begin
              if (nflt_s_q) fault_d = 1'b0;
            end else begin
              num_lines_d = num_lines;
              spl_d       = steps_per_line;
              line_cnt_d  = '0;
              if (num_lines == 16'd0) begin
                done_d = 1'b1;
              end else begin
                state_d = ST_WAKE;
                dir_d   = 1'b0;
              end
            end
          end
        end
        ST_WAKE: begin
          if (timer_q == TMR_W'(WAKE_CYC - 1)) begin
            if (!nhome_s_q) begin
              state_d = ST_SETTLE;
              dir_d   = 1'b1;
            end else begin
              state_d  = ST_HOME;
              pg_req   = 1'b1;
              pg_count = STEP_CNT_W'(HOME_MAX_STEPS);
            end
          end
        end
        ST_HOME: begin
          if (pg_tick && !nhome_s_q) begin
            state_d = ST_SETTLE;
            dir_d   = 1'b1;
          end else if (pg_last || !pg_busy) begin
            state_d = ST_FAULT;
          end
        end
        ST_STEP: begin
          if (pg_last || !pg_busy) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_q == TMR_W'(SETTLE_CYC - 1)) state_d = ST_EXPOSE;
        end
        ST_EXPOSE: begin
          if (line_done) begin
            line_cnt_d = line_cnt_q + 16'd1;
            if (line_cnt_d == num_lines_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (spl_q == 8'd0) begin
              state_d = ST_SETTLE;
            end else begin
              state_d  = ST_STEP;
              pg_req   = 1'b1;
              pg_count = STEP_CNT_W'(spl_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d == ST_FAULT) fault_d = 1'b1;
    pg_cancel = (state_d != ST_HOME) && (state_d != ST_STEP);
    timer_d   = (state_d != state_q) ? '0 : timer_q + 1'b1;
  end

  always_comb begin
    mtr_nen  = 1'b1;
    mtr_slp  = 1'b0;
    mtr_nrst = 1'b0;
    mtr_step = 1'b0;
    ccd_en   = 1'b0;
    case (state_q)
      ST_WAKE, ST_HOME, ST_STEP, ST_SETTLE, ST_EXPOSE: begin
        mtr_nen  = 1'b0;
        mtr_slp  = 1'b1;
        mtr_nrst = 1'b1;
      end
      default: ;
    endcase
    if ((state_q == ST_HOME) || (state_q == ST_STEP)) mtr_step = pg_step;
    if (state_q == ST_EXPOSE) ccd_en = 1'b1;
  end

  assign mtr_dir  = dir_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign fault    = fault_q;
  assign line_cnt = line_cnt_q;

  step_pulse_gen #(
    .HALF_CYC (STEP_HALF_CYC),
    .CNT_W    (STEP_CNT_W)
  ) u_pulse_gen (
    .clk    (clk_80M),
    .nrst   (nrst),
    .req    (pg_req),
    .cancel (pg_cancel),
    .count  (pg_count),
    .step   (pg_step),
    .busy   (pg_busy),
    .tick   (pg_tick),
    .last   (pg_last)
  );

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer with short timing constants and a home-switch / CCD responder model.
module tb_scan_sequencer;

  localparam int HALF   = 2;
  localparam int SETTLE = 5;
  localparam int WAKE   = 3;
  localparam int HMAX   = 8;

  logic        clk_80M = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_lines = '0;
  logic [7:0]  steps_per_line = '0;
  logic        line_done;
  logic        mtr_nhome = 1'b1;
  logic        mtr_nflt = 1'b1;
  logic        mtr_step, mtr_dir, mtr_nen, mtr_nrst, mtr_slp;
  logic        ccd_en, busy, done, fault;
  logic [15:0] line_cnt;

  logic ld_auto = 1'b0;
  logic ld_man = 1'b0;
  bit   ld_auto_en = 1'b1;
  bit   cut_ok = 1'b0;
  bit   step_prev = 1'b0;
  bit   dir_at_rise = 1'b0;
  int   exp_cyc = 0;
  int   hi_len = 0;
  int   home_after = 0;
  int   d0_cnt = 0, d1_cnt = 0, done_cnt = 0;
  int   n_checks = 0, n_pass = 0;

  typedef struct {
    int nl;
    int spl;
    int home_after;
    bit extra_start;
    int e_d0;
    int e_d1;
    int e_lc;
    int e_done;
    int e_fault;
  } scen_t;

  scen_t tbl[4];
  scen_t sb_q[$];

  assign line_done = ld_auto | ld_man;

  always #5 clk_80M = ~clk_80M;

  scan_sequencer #(
    .STEP_HALF_CYC  (HALF),
    .SETTLE_CYC     (SETTLE),
    .WAKE_CYC       (WAKE),
    .HOME_MAX_STEPS (HMAX)
  ) dut (
    .clk_80M        (clk_80M),
    .nrst           (nrst),
    .start          (start),
    .abort          (abort),
    .num_lines      (num_lines),
    .steps_per_line (steps_per_line),
    .line_done      (line_done),
    .mtr_nhome      (mtr_nhome),
    .mtr_nflt       (mtr_nflt),
    .mtr_step       (mtr_step),
    .mtr_dir        (mtr_dir),
    .mtr_nen        (mtr_nen),
    .mtr_nrst       (mtr_nrst),
    .mtr_slp        (mtr_slp),
    .ccd_en         (ccd_en),
    .busy           (busy),
    .done           (done),
    .fault          (fault),
    .line_cnt       (line_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Pulse monitor and home-switch model: the switch closes once home_after dir=0 pulses have started.
  initial begin
    forever begin
      @(negedge clk_80M);
      if (mtr_step && !step_prev) begin
        hi_len      = 1;
        dir_at_rise = mtr_dir;
        if (mtr_dir) d1_cnt++;
        else d0_cnt++;
      end else if (mtr_step) begin
        hi_len++;
      end else if (step_prev && !cut_ok) begin
        check("pulse_high_cyc", hi_len, HALF);
        check("dir_stable_in_pulse", mtr_dir, dir_at_rise);
      end
      step_prev = mtr_step;
      if (done) done_cnt++;
      mtr_nhome = !((home_after != 0) && (d0_cnt >= home_after));
    end
  end

  // CCD model: line_done pulse on the 10th clock of each enable window.
  initial begin
    forever begin
      @(negedge clk_80M);
      ld_auto = 1'b0;
      if (ccd_en && ld_auto_en) begin
        exp_cyc++;
        if (exp_cyc == 10) ld_auto = 1'b1;
      end else begin
        exp_cyc = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_80M);
      #1;
    end
  endtask

  task automatic pulse_start(input int nl, input int spl);
    num_lines      = 16'(nl);
    steps_per_line = 8'(spl);
    start          = 1'b1;
    tick(1);
    start          = 1'b0;
  endtask

  task automatic prep(input int ha);
    home_after = ha;
    d0_cnt     = 0;
    d1_cnt     = 0;
    done_cnt   = 0;
    tick(3);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && busy; i++) tick(1);
    check(name, busy, 0);
  endtask

  task automatic run_scen(input scen_t s);
    scen_t e;
    prep(s.home_after);
    sb_q.push_back(s);
    pulse_start(s.nl, s.spl);
    check("busy_after_start", busy, 1);
    if (s.extra_start) begin
      tick(4);
      pulse_start(7, 1);
    end
    wait_idle("scen_busy_low");
    tick(2);
    e = sb_q.pop_front();
    check("dir0_pulses", d0_cnt, e.e_d0);
    check("dir1_pulses", d1_cnt, e.e_d1);
    check("line_cnt", line_cnt, e.e_lc);
    check("done_pulses", done_cnt, e.e_done);
    check("fault_flag", fault, e.e_fault);
    check("nen_after_scan", mtr_nen, 1);
  endtask

  initial begin
    // nl, spl, home_after, extra_start, exp dir0, exp dir1, exp line_cnt, exp done, exp fault
    tbl[0] = '{2, 4, 3, 1'b0, 3, 4, 2, 1, 0};
    tbl[1] = '{3, 0, 1, 1'b0, 1, 0, 3, 1, 0};
    tbl[2] = '{3, 3, 2, 1'b1, 2, 6, 3, 1, 0};
    tbl[3] = '{1, 2, 0, 1'b0, HMAX, 0, 0, 0, 1};

    tick(2);
    check("reset_outs", {mtr_step, mtr_dir, mtr_nen, mtr_nrst, mtr_slp, ccd_en, busy, done, fault},
          9'b0_0_1_0_0_0_0_0_0);
    check("reset_line_cnt", line_cnt, 0);
    nrst = 1'b1;
    tick(2);

    // Zero-line scan: immediate done, motor pins untouched.
    pulse_start(0, 5);
    check("nl0_done", done, 1);
    check("nl0_busy", busy, 0);
    check("nl0_pins", {mtr_step, mtr_dir, mtr_nen, mtr_nrst, mtr_slp}, 5'b0_0_1_0_0);
    tick(1);
    check("nl0_done_one_cycle", done, 0);

    foreach (tbl[i]) run_scen(tbl[i]);

    // Homing fault left set: a start with nflt high only clears it.
    pulse_start(1, 1);
    check("fault_clear", fault, 0);
    check("fault_clear_no_busy", busy, 0);
    tick(2);
    check("fault_clear_no_scan", busy, 0);

    // Driver fault during the second STEP.
    prep(1);
    pulse_start(3, 4);
    for (int i = 0; i < 2000 && d1_cnt < 5; i++) tick(1);
    check("reach_second_step", int'(d1_cnt >= 5), 1);
    cut_ok   = 1'b1;
    mtr_nflt = 1'b0;
    tick(3);
    check("nflt_step_low", mtr_step, 0);
    check("nflt_fault_set", fault, 1);
    check("nflt_ccd_off", ccd_en, 0);
    tick(1);
    check("nflt_busy_low", busy, 0);
    check("nflt_nen", mtr_nen, 1);
    check("nflt_line_cnt", line_cnt, 2);
    pulse_start(1, 1);
    check("start_nflt_low_keeps_fault", fault, 1);
    check("start_nflt_low_no_busy", busy, 0);
    mtr_nflt = 1'b1;
    tick(3);
    pulse_start(1, 1);
    check("start_nflt_high_clears", fault, 0);
    check("start_nflt_high_no_busy", busy, 0);
    tick(2);
    check("nflt_no_done", done_cnt, 0);
    cut_ok = 1'b0;

    // line_done in SETTLE ignored, then abort during the second EXPOSE.
    prep(1);
    pulse_start(2, 1);
    for (int i = 0; i < 200 && d0_cnt < 1; i++) tick(1);
    tick(4);
    ld_man = 1'b1;
    tick(1);
    ld_man = 1'b0;
    for (int i = 0; i < 200 && !ccd_en; i++) tick(1);
    check("settle_line_done_ignored", line_cnt, 0);
    for (int i = 0; i < 200 && line_cnt != 16'd1; i++) tick(1);
    ld_auto_en = 1'b0;
    for (int i = 0; i < 200 && !ccd_en; i++) tick(1);
    check("second_expose_reached", ccd_en, 1);
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_ccd_off", ccd_en, 0);
    check("abort_busy_low", busy, 0);
    check("abort_line_cnt_held", line_cnt, 1);
    check("abort_nen", mtr_nen, 1);
    tick(5);
    check("abort_no_done", done_cnt, 0);
    ld_auto_en = 1'b1;

    // One-clock reset in the middle of a step pulse of the second STEP.
    prep(1);
    pulse_start(3, 4);
    for (int i = 0; i < 2000 && !(d1_cnt >= 6 && mtr_step); i++) tick(1);
    check("reach_mid_pulse", mtr_step, 1);
    cut_ok = 1'b1;
    nrst   = 1'b0;
    tick(1);
    check("midscan_reset_outs", {mtr_step, mtr_dir, mtr_nen, mtr_nrst, mtr_slp, ccd_en, busy, done, fault},
          9'b0_0_1_0_0_0_0_0_0);
    check("midscan_reset_line_cnt", line_cnt, 0);
    nrst = 1'b1;
    tick(3);
    check("midscan_reset_stays_idle", busy, 0);
    cut_ok = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
